// File: rtl/spawn_scheduler.sv
// Spawn pacing controller for the 8-slot enemy array: LFSR randomness, level-scaled
// countdown between spawns, enemy-count cap and post-collision grace period.
module spawn_scheduler #(
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter logic [7:0]  BASE_INTERVAL   = 8'd120,
  parameter logic [7:0]  MIN_INTERVAL    = 8'd20,
  parameter logic [7:0]  STEP            = 8'd10,
  parameter logic [7:0]  KILLS_PER_LEVEL = 8'd8,
  parameter logic [3:0]  MAX_ENEMIES     = 4'd8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       game_active_i,
  input  logic [3:0] enemy_count_i,
  input  logic [3:0] kill_count_i,
  input  logic       collision_i,
  output logic [5:0] random_number_o,
  output logic       spawn_o,
  output logic [3:0] level_o
);

  typedef enum logic [1:0] {StIdle, StWait, StHold, StFire} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  kacc_q, kacc_d;
  logic [3:0]  level_q, level_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        spawn_q;

  logic [11:0]        level_dec;
  logic signed [11:0] interval_raw;
  logic [7:0]         interval;
  logic [8:0]         kill_sum;
  logic [7:0]         kill_sat;
  logic               room;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Signed 12-bit difference so high levels clamp to the floor instead of wrapping.
  assign level_dec    = 12'(level_q) * 12'(STEP);
  assign interval_raw = $signed({4'd0, BASE_INTERVAL}) - $signed(level_dec);
  assign interval     = (interval_raw < $signed({4'd0, MIN_INTERVAL})) ? MIN_INTERVAL
                                                                     : interval_raw[7:0];

  assign room = enemy_count_i < MAX_ENEMIES;

  always_comb begin
    kill_sum = {1'b0, kacc_q} + {5'd0, kill_count_i};
    kill_sat = kill_sum[8] ? 8'hFF : kill_sum[7:0];
    kacc_d   = kill_sat;
    level_d  = level_q;
    if (kill_sat >= KILLS_PER_LEVEL) begin
      kacc_d  = kill_sat - KILLS_PER_LEVEL;
      level_d = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      kacc_q  <= 8'd0;
      level_q <= 4'd0;
      lfsr_q  <= LFSR_SEED;
      spawn_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      spawn_q <= 1'b0;
      if (!game_active_i) begin
        state_q <= StIdle;
        cnt_q   <= 8'd0;
        kacc_q  <= 8'd0;
        level_q <= 4'd0;
      end else if (state_q == StIdle) begin
        state_q <= StWait;
        cnt_q   <= interval;
        kacc_q  <= 8'd0;
        level_q <= 4'd0;
      end else begin
        kacc_q  <= kacc_d;
        level_q <= level_d;
        if (collision_i) begin
          state_q <= StWait;
          cnt_q   <= BASE_INTERVAL;
        end else begin
          case (state_q)
            StWait: begin
              if (tick_i) begin
                cnt_q <= cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                  if (room) begin
                    state_q <= StFire;
                    spawn_q <= 1'b1;
                  end else begin
                    state_q <= StHold;
                  end
                end
              end
            end
            StHold: begin
              if (room) begin
                state_q <= StFire;
                spawn_q <= 1'b1;
              end
            end
            StFire: begin
              // Reload uses the level held during the spawn cycle.
              state_q <= StWait;
              cnt_q   <= interval;
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

  assign random_number_o = lfsr_q[5:0];
  assign spawn_o         = spawn_q;
  assign level_o         = level_q;

endmodule

// File: doc/spawn_scheduler.md
# spawn_scheduler

Upstream controller for the 8-slot enemy array. Generates the `random_number` and `spawn` pulse that the array uses to place and type new enemies. Paces spawns on a frame-tick countdown whose interval shrinks as the level rises. Level is derived from accumulated kills. Honours an enemy-count cap and grants a grace period after a player collision.

## Interface
- `LFSR_SEED`, 16'hACE1, non-zero LFSR reset value.
- `BASE_INTERVAL`, 8'd120, ticks between spawns at level 0.
- `MIN_INTERVAL`, 8'd20, floor on the spawn interval.
- `STEP`, 8'd10, interval reduction per level.
- `KILLS_PER_LEVEL`, 8'd8, kills needed to advance one level.
- `MAX_ENEMIES`, 4'd8, no spawn while `enemy_count` >= this.
- `clk`  in  1  system clock; one clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tick`  in  1  one-cycle frame strobe; the countdown time base.
- `game_active`  in  1  level; 0 holds the block idle.
- `enemy_count`  in  4  live enemies, from the array.
- `kill_count`  in  4  kills this cycle, 0..8, from the array.
- `collision`  in  1  player hit this cycle, from the array.
- `random_number`  out  6  `lfsr[5:0]`; [3:0] is the angle, [5:4] is the kind.
- `spawn`  out  1  registered one-cycle spawn request.
- `level`  out  4  current difficulty level, saturates at 15.

## Operation
- **LFSR**
  - 16-bit Galois, right-shift, feedback mask 16'hB400.
  - Advances every clk regardless of state; `random_number` is registered bits [5:0].
- **Interval**
  - `interval = max(BASE_INTERVAL - level*STEP, MIN_INTERVAL)`.
  - Computed in 12-bit signed arithmetic so that underflow clamps to `MIN_INTERVAL`.
  - Result is 8 bits.
- **Kill accumulator**
  - `kacc` is 8 bits, saturating; each cycle `kacc += kill_count`.
  - If the sum >= `KILLS_PER_LEVEL` in a cycle: `kacc <= sum - KILLS_PER_LEVEL` and `level` increments, saturating at 15.
  - At most one level increment per cycle.
  - At level 15, `kacc` still accumulates and subtracts; `level` stays 15.
- **FSM** (states IDLE, WAIT, HOLD, FIRE):
  - IDLE: `level`, `kacc` and `cnt` are cleared. On `game_active`=1, go to WAIT and load `cnt <= interval`.
  - WAIT: `cnt` decrements on `tick`. On a tick with `cnt`==1: go to FIRE if `enemy_count` < `MAX_ENEMIES`, else HOLD.
  - HOLD: go to FIRE on the first cycle `enemy_count` < `MAX_ENEMIES`. No tick is needed.
  - FIRE: `spawn` is high this cycle only. Next state is WAIT with `cnt <= interval`, using the level as of the FIRE cycle.
- **Collision**
  - From WAIT, HOLD or FIRE: `cnt <= BASE_INTERVAL`, next state WAIT.
  - A spawn already registered in FIRE still completes that cycle.
  - `level` is unaffected.
- **Priority, highest first**
  1. `rst_n`=0
  2. `game_active`=0 (go to IDLE next cycle from any state)
  3. `collision`
  4. normal transitions
- **Spawn acceptance**
  - The block does not check whether the array accepted the spawn; an occupied angle means a lost spawn by design.
  - The interval restarts either way.

## Timing
- **Reset values:**
  - `random_number` = 6'h21, `spawn` = 0, `level` = 0
  - state IDLE, `cnt` = 0, `kacc` = 0, `lfsr` = `LFSR_SEED`
- **First spawn latency:** rising `game_active` at cycle C gives WAIT at C+1. `spawn` is high one cycle after the `interval`-th tick.
- **Steady-state period:** `interval` ticks plus 1 clk.
- **Kill to level latency:** `level` updates the cycle after the qualifying `kill_count`. The new value affects the next interval load.
- **`spawn` pulse:** never high for two consecutive cycles.
- **`spawn` while inactive:** never high in IDLE, or in the cycle after `game_active` falls.
- **Reset mid-operation:** outputs return to reset values on the next edge. Any `spawn` pulse in flight is cancelled.

## Test plan
- **Reset and LFSR:** hold `rst_n`=0 for 3 clk, then release.
  - `random_number`=6'h21 during reset.
  - The LFSR sequence matches the 16'hB400 model for 1000 cycles and never reaches zero.
- **Base pacing:** `game_active`=1, `enemy_count`=0, tick every 4 clk.
  - `spawn` pulses exactly every 120 ticks, each pulse one clk wide.
  - `level` stays 0.
- **Level ramp and clamp:** drive `kill_count`=4 for 2 cycles.
  - `level`=1 and the next interval is 110 ticks.
  - Continue to 22 kills total gives `level`=2, `kacc`=6.
  - Forcing `level` to 11 gives an interval of 20, not 10.
- **Cap/HOLD:** `enemy_count`=8 when the countdown expires.
  - No `spawn` while the count stays 8.
  - Drop the count to 7: `spawn` is high on the next clk with no tick needed.
- **Collision grace:** assert `collision` at `cnt`=5 in WAIT.
  - The next `spawn` arrives 120 ticks later.
  - Collision coincident with FIRE: that spawn still occurs and the following wait is 120 ticks.
- **Abort:** drop `game_active` mid-WAIT, and separately assert `rst_n`=0 in the HOLD state.
  - IDLE next cycle; `level`=0, `spawn`=0.
  - Re-enabling restarts with a full `BASE_INTERVAL`.
